// File: rtl/rf_iterative_multiplier.sv
// Multi-cycle unsigned shift-add multiplier between a dual-read register-file RAM and its write port.
// Fetches two operands, iterates one partial product per cycle, then writes the low half back.
module rf_iterative_multiplier #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iSourceA,
    input  logic [ADDR_WIDTH-1:0] iSourceB,
    input  logic [ADDR_WIDTH-1:0] iDest,
    output logic [ADDR_WIDTH-1:0] oReadAddress0,
    output logic [ADDR_WIDTH-1:0] oReadAddress1,
    input  logic [DATA_WIDTH-1:0] iOperandA,
    input  logic [DATA_WIDTH-1:0] iOperandB,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData,
    output logic [DATA_WIDTH-1:0] oResultHigh,
    output logic                  oOverflow,
    output logic                  oBusy,
    output logic                  oDone
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_MULT,
        S_WRITE
    } state_t;

    state_t                  state_q,          state_d;
    logic [ADDR_WIDTH-1:0]   read_addr0_q,     read_addr0_d;
    logic [ADDR_WIDTH-1:0]   read_addr1_q,     read_addr1_d;
    logic [ADDR_WIDTH-1:0]   dest_q,           dest_d;
    logic [DATA_WIDTH-1:0]   multiplicand_q,   multiplicand_d;
    logic [DATA_WIDTH-1:0]   multiplier_q,     multiplier_d;
    logic [2*DATA_WIDTH-1:0] acc_q,            acc_d;
    logic [CNT_W-1:0]        count_q,          count_d;
    logic                    write_en_q,       write_en_d;
    logic [ADDR_WIDTH-1:0]   write_addr_q,     write_addr_d;
    logic [DATA_WIDTH-1:0]   write_data_q,     write_data_d;
    logic [DATA_WIDTH-1:0]   result_high_q,    result_high_d;
    logic                    overflow_q,       overflow_d;
    logic                    busy_q,           busy_d;
    logic                    done_q,           done_d;

    logic [DATA_WIDTH:0]     partial_sum;
    logic [2*DATA_WIDTH-1:0] acc_step;

    // One shift-add step: the carry out of the upper-half add becomes the new MSB after the shift.
    assign partial_sum = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                       + (multiplier_q[0] ? {1'b0, multiplicand_q} : '0);
    assign acc_step    = {partial_sum, acc_q[DATA_WIDTH-1:1]};

    always_comb begin
        // NOTE: every *_d gets a default here so no path through the case leaves one unassigned (no latch).
        state_d        = state_q;
        read_addr0_d   = read_addr0_q;
        read_addr1_d   = read_addr1_q;
        dest_d         = dest_q;
        multiplicand_d = multiplicand_q;
        multiplier_d   = multiplier_q;
        acc_d          = acc_q;
        count_d        = count_q;
        write_en_d     = 1'b0;
        done_d         = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        result_high_d  = result_high_q;
        overflow_d     = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    read_addr0_d = iSourceA;
                    read_addr1_d = iSourceB;
                    dest_d       = iDest;
                    state_d      = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                multiplicand_d = iOperandA;
                multiplier_d   = iOperandB;
                acc_d          = '0;
                count_d        = '0;
                state_d        = S_MULT;
            end
            S_MULT: begin
                acc_d        = acc_step;
                multiplier_d = multiplier_q >> 1;
                count_d      = count_q + CNT_W'(1);
                // Last iteration: load the write-back outputs from the final accumulator value.
                if (count_q == CNT_W'(DATA_WIDTH - 1)) begin
                    state_d       = S_WRITE;
                    write_en_d    = 1'b1;
                    done_d        = 1'b1;
                    write_addr_d  = dest_q;
                    write_data_d  = acc_step[DATA_WIDTH-1:0];
                    result_high_d = acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
                    overflow_d    = |acc_step[2*DATA_WIDTH-1:DATA_WIDTH];
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q        <= S_IDLE;
            read_addr0_q   <= '0;
            read_addr1_q   <= '0;
            dest_q         <= '0;
            multiplicand_q <= '0;
            multiplier_q   <= '0;
            acc_q          <= '0;
            count_q        <= '0;
            write_en_q     <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            result_high_q  <= '0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            read_addr0_q   <= read_addr0_d;
            read_addr1_q   <= read_addr1_d;
            dest_q         <= dest_d;
            multiplicand_q <= multiplicand_d;
            multiplier_q   <= multiplier_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            write_en_q     <= write_en_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            result_high_q  <= result_high_d;
            overflow_q     <= overflow_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign oReadAddress0 = read_addr0_q;
    assign oReadAddress1 = read_addr1_q;
    assign oWriteEnable  = write_en_q;
    assign oWriteAddress = write_addr_q;
    assign oWriteData    = write_data_q;
    assign oResultHigh   = result_high_q;
    assign oOverflow     = overflow_q;
    assign oBusy         = busy_q;
    assign oDone         = done_q;

endmodule

// File: tb/tb_rf_iterative_multiplier.sv
// Bench for rf_iterative_multiplier: a behavioural register-file RAM, a vector table and a
// write-back scoreboard, plus hand sequences for ignored starts, mid-run reset and back-to-back use.
module tb_rf_iterative_multiplier;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] src_a, src_b, dest;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] rd0, rd1;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] res_hi;
    logic          ovf;
    logic          busy;
    logic          done;

    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int expected_pulses = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic          ovf;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [AW-1:0] sa;
        logic [AW-1:0] sb;
        logic [AW-1:0] d;
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic          ov;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    rf_iterative_multiplier #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock         (clk),
        .Reset         (rst_n),
        .iStart        (start),
        .iSourceA      (src_a),
        .iSourceB      (src_b),
        .iDest         (dest),
        .oReadAddress0 (ra0),
        .oReadAddress1 (ra1),
        .iOperandA     (rd0),
        .iOperandB     (rd1),
        .oWriteEnable  (we),
        .oWriteAddress (waddr),
        .oWriteData    (wdata),
        .oResultHigh   (res_hi),
        .oOverflow     (ovf),
        .oBusy         (busy),
        .oDone         (done)
    );

    // Register-file RAM: synchronous reads, one write port, plus a bench-only preload port.
    always @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
        if (pre_we) ram[pre_addr] <= pre_data;
        rd0 <= ram[ra0];
        rd1 <= ram[ra1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write-back pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && we) begin
            pulses++;
            check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(waddr), 32'(e.addr));
                check("wr_data", 32'(wdata), 32'(e.lo));
                check("res_high", 32'(res_hi), 32'(e.hi));
                check("overflow", 32'(ovf), 32'(e.ovf));
                check("done_with_we", 32'(done), 32'd1);
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic push_exp(input logic [AW-1:0] d, input logic [2*DW-1:0] prod);
        sb_q.push_back('{addr: d, lo: prod[DW-1:0], hi: prod[2*DW-1:DW], ovf: |prod[2*DW-1:DW]});
        expected_pulses++;
    endtask

    // Drives a one-cycle start; returns 1 ns after the sampling edge E0.
    task automatic start_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d);
        @(negedge clk);
        start = 1'b1; src_a = a; src_b = b; dest = d;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    // Waits (bounded) for the write pulse, checks its latency, then steps past the commit edge.
    task automatic wait_write(input int exp_lat, input bit start_in_write);
        int k;
        k = 0;
        while (k <= 40) begin
            @(posedge clk);
            k++;
            #1;
            if (we) break;
        end
        check("latency", 32'(k), 32'(exp_lat));
        if (start_in_write) begin
            start = 1'b1; src_a = 8'd1; src_b = 8'd2; dest = 8'd30;
        end
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_after_write", 32'(busy), 32'd0);
        check("we_after_write", 32'(we), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] a_val, b_val;
        logic [31:0]   prod;

        rst_n = 1'b0; start = 1'b0; src_a = '0; src_b = '0; dest = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        vecs[0] = '{8'd1,  8'd2,  8'd3,  16'd3,      16'd5,      16'd15,     16'h0000, 1'b0};
        vecs[1] = '{8'd1,  8'd2,  8'd4,  16'hFFFF,   16'hFFFF,   16'h0001,   16'hFFFE, 1'b1};
        vecs[2] = '{8'd1,  8'd2,  8'd6,  16'h0000,   16'h1234,   16'h0000,   16'h0000, 1'b0};
        vecs[3] = '{8'd1,  8'd2,  8'd6,  16'h0100,   16'h0100,   16'h0000,   16'h0001, 1'b1};
        vecs[4] = '{8'd9,  8'd9,  8'd10, 16'h00FF,   16'h00FF,   16'hFE01,   16'h0000, 1'b0};
        vecs[5] = '{8'd11, 8'd12, 8'd11, 16'h1234,   16'h0010,   16'h2340,   16'h0001, 1'b1};
        vecs[6] = '{8'd13, 8'd14, 8'd15, 16'h8000,   16'h0002,   16'h0000,   16'h0001, 1'b1};
        vecs[7] = '{8'd16, 8'd17, 8'd18, 16'hFFFF,   16'h0001,   16'hFFFF,   16'h0000, 1'b0};

        #3;
        check("rst_we", 32'(we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ra0", 32'(ra0), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            preload(vecs[i].sa, vecs[i].va);
            preload(vecs[i].sb, vecs[i].vb);
            sb_q.push_back('{addr: vecs[i].d, lo: vecs[i].lo, hi: vecs[i].hi, ovf: vecs[i].ov});
            expected_pulses++;
            start_op(vecs[i].sa, vecs[i].sb, vecs[i].d);
            wait_write(18, 1'b0);
            @(negedge clk);
            check("ram_dest", 32'(ram[vecs[i].d]), 32'(vecs[i].lo));
        end

        // A second start at E5 with another destination must be ignored.
        preload(8'd1, 16'd7);
        preload(8'd2, 16'd9);
        preload(8'd22, 16'h5555);
        push_exp(8'd21, 32'd63);
        start_op(8'd1, 8'd2, 8'd21);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dest = 8'd22;
        @(posedge clk);
        #1 start = 1'b0;
        wait_write(13, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        check("ignored_busy", 32'(busy), 32'd0);
        check("ram_r21", 32'(ram[21]), 32'd63);
        check("ram_r22_kept", 32'(ram[22]), 32'h5555);
        check("pulse_count", 32'(pulses), 32'(expected_pulses));

        // Reset asserted during MULT at E8 aborts with no write-back.
        preload(8'd7, 16'hAAAA);
        start_op(8'd1, 8'd2, 8'd7);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", 32'(we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ra0", 32'(ra0), 32'd0);
        check("abort_ra1", 32'(ra1), 32'd0);
        check("abort_waddr", 32'(waddr), 32'd0);
        check("abort_wdata", 32'(wdata), 32'd0);
        check("abort_hi_ovf", {31'd0, ovf} | 32'(res_hi), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("abort_ram_kept", 32'(ram[7]), 32'hAAAA);
        check("abort_pulses", 32'(pulses), 32'(expected_pulses));

        // Back-to-back: second start reads the value committed by the first.
        preload(8'd1, 16'd2);
        preload(8'd2, 16'd3);
        push_exp(8'd1, 32'd6);
        start_op(8'd1, 8'd2, 8'd1);
        wait_write(18, 1'b0);
        push_exp(8'd5, 32'd36);
        start_op(8'd1, 8'd1, 8'd5);
        wait_write(18, 1'b0);
        @(negedge clk);
        check("b2b_r1", 32'(ram[1]), 32'd6);
        check("b2b_r5", 32'(ram[5]), 32'd36);

        // Random operands; the first one also pulses start during WRITE, which must be ignored.
        preload(8'd30, 16'h0BAD);
        for (int i = 0; i < 4; i++) begin
            a_val = DW'($urandom);
            b_val = DW'($urandom);
            prod  = 32'(a_val) * 32'(b_val);
            preload(AW'(40 + 2*i), a_val);
            preload(AW'(41 + 2*i), b_val);
            push_exp(AW'(50 + i), prod);
            start_op(AW'(40 + 2*i), AW'(41 + 2*i), AW'(50 + i));
            wait_write(18, i == 0);
            @(negedge clk);
            check("rand_ram", 32'(ram[50 + i]), 32'(prod[DW-1:0]));
        end
        repeat (25) @(posedge clk);
        #1;
        check("write_in_write_ignored", 32'(ram[30]), 32'h0BAD);
        check("final_pulses", 32'(pulses), 32'(expected_pulses));
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_iterative_multiplier.md
Name: rf_iterative_multiplier

Overview:
- Multi-cycle execute stage sitting between the dual-read-port register-file RAM and its write port.
- On a start request it presents two source addresses to the RAM read ports and captures the two operands one cycle later, after the RAM's synchronous read.
- It computes the unsigned product by iterative shift-add, then drives a one-cycle write-back of the low half to a destination register.
- The high half and an overflow flag are held on side outputs.

Parameters:
DATA_WIDTH, 16, operand/register width in bits; must equal the RAM DATA_WIDTH.
ADDR_WIDTH, 8, register address width; must equal the RAM ADDR_WIDTH.

Ports:
Clock  input  1  rising-edge clock shared with the RAM.
Reset  input  1  asynchronous, active-low reset.
iStart  input  1  request; sampled only in IDLE.
iSourceA  input  ADDR_WIDTH  multiplicand register address.
iSourceB  input  ADDR_WIDTH  multiplier register address.
iDest  input  ADDR_WIDTH  destination register address.
oReadAddress0  output  ADDR_WIDTH  to RAM iReadAddress0 (registered).
oReadAddress1  output  ADDR_WIDTH  to RAM iReadAddress1 (registered).
iOperandA  input  DATA_WIDTH  from RAM oDataOut0.
iOperandB  input  DATA_WIDTH  from RAM oDataOut1.
oWriteEnable  output  1  to RAM iWriteEnable; one-cycle pulse.
oWriteAddress  output  ADDR_WIDTH  to RAM iWriteAddress.
oWriteData  output  DATA_WIDTH  to RAM iDataIn; product[DATA_WIDTH-1:0].
oResultHigh  output  DATA_WIDTH  product[2*DATA_WIDTH-1:DATA_WIDTH]; held until the next WRITE.
oOverflow  output  1  1 when oResultHigh != 0; held like oResultHigh.
oBusy  output  1  1 whenever state != IDLE.
oDone  output  1  one-cycle pulse coincident with oWriteEnable.

Behaviour:
Reset (Reset=0, asynchronous):
- State goes to IDLE.
- All outputs, the accumulator, operand registers and counter are cleared to 0.
- Reset asserted mid-operation aborts the operation; no write-back occurs.

State machine, registered transitions:
- IDLE --iStart--> FETCH. At edge E0, oReadAddress0<=iSourceA, oReadAddress1<=iSourceB, and iDest is latched internally.
- FETCH --> LOAD unconditionally (edge E1). The RAM registers Ram[address] on this edge.
- LOAD --> MULT (edge E2):
  - multiplicand<=iOperandA, multiplier<=iOperandB;
  - accumulator (2*DATA_WIDTH bits) <= 0;
  - counter<=0.
- MULT, one iteration per edge:
  - if multiplier[0]=1, the upper half of the accumulator adds the multiplicand with carry-out kept (DATA_WIDTH+1-bit add);
  - then {carry, accumulator} shifts right by 1, multiplier shifts right by 1, and the counter increments;
  - after exactly DATA_WIDTH iterations (edges E3..E(2+DATA_WIDTH)) the state goes to WRITE.
- WRITE, for one cycle:
  - oWriteEnable=1, oDone=1, oWriteAddress=latched iDest, oWriteData=low half;
  - oResultHigh and oOverflow update on entry;
  - the next edge returns the state to IDLE, where the RAM commits the write.

Outputs and latency:
- oWriteEnable and oDone are registered and are 0 in every state except WRITE.
- Latency: iStart sampled at E0 -> oWriteEnable high during the cycle after edge E(2+DATA_WIDTH), i.e. DATA_WIDTH+3 edges to the commit edge (19 for width 16).

Boundary conditions:
- iStart while oBusy=1 (including during WRITE) is ignored: not queued, no effect.
- iStart in the IDLE cycle immediately after WRITE is accepted. Its reads occur after the previous write committed, so a source equal to the previous iDest yields the new value.
- iSourceA=iSourceB is legal; the register is squared.
- iDest equal to a source is legal; the source is overwritten only at write-back.
- Operand changes on iOperandA/B outside LOAD have no effect.
- oReadAddress0/1 hold their values until the next accepted start.
- Arithmetic is unsigned; the product is exact in 2*DATA_WIDTH bits, with no truncation before the split.

Test Plan:
1. Preload R1=3, R2=5; start A=1,B=2,Dest=3 -> oWriteEnable pulse 18 edges after E0 with oWriteAddress=3, oWriteData=15, oResultHigh=0, oOverflow=0; RAM R3=15 afterwards.
2. R1=0xFFFF, R2=0xFFFF, Dest=4 -> oWriteData=0x0001, oResultHigh=0xFFFE, oOverflow=1.
3. R1=0, R2=0x1234 -> oWriteData=0, oOverflow=0; R1=0x0100, R2=0x0100 -> oWriteData=0x0000, oResultHigh=0x0001, oOverflow=1.
4. iStart pulsed again at E5 with a different Dest -> ignored; exactly one oWriteEnable pulse, at the original Dest.
5. Reset driven low during MULT (E8) -> all outputs 0 immediately, oBusy=0, no write; the RAM destination is unchanged.
6. Back-to-back: R1=2, R2=3, start A=1,B=2,Dest=1, then start in the next IDLE cycle A=1,B=1,Dest=5 -> R1=6, then R5=36.
